// File: rtl/mem_stage_lsu_pkg.sv
// Shared pipeline types for the memory-stage load/store unit: access
// types, FSM state encoding and small decode helpers.
package mem_stage_lsu_pkg;

  typedef enum logic [2:0] {
    ACC_WORD   = 3'd0,
    ACC_BYTE_U = 3'd1,
    ACC_BYTE_S = 3'd2,
    ACC_HALF_U = 3'd3,
    ACC_HALF_S = 3'd4
  } acc_t;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_REQ  = 2'd1;
  localparam lsu_state_t ST_DONE = 2'd2;

  // Encodings outside acc_t fall back to a full-word access.
  function automatic acc_t norm_acc(input logic [2:0] raw);
    case (raw)
      3'd1:    return ACC_BYTE_U;
      3'd2:    return ACC_BYTE_S;
      3'd3:    return ACC_HALF_U;
      3'd4:    return ACC_HALF_S;
      default: return ACC_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input acc_t acc, input logic [1:0] lo);
    case (acc)
      ACC_WORD:               return (lo == 2'b00);
      ACC_HALF_U, ACC_HALF_S: return !lo[0];
      default:                return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_lane.sv
// Byte-lane steering: store data replication / strobes and load
// lane selection with zero or sign extension.
import mem_stage_lsu_pkg::*;

module lsu_lane (
  input  acc_t        acc,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_rep,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wstrb     = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (acc)
      ACC_BYTE_U, ACC_BYTE_S: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      ACC_HALF_U, ACC_HALF_S: begin
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    case (acc)
      ACC_BYTE_U: rdata_ext = {24'b0, byte_sel};
      ACC_BYTE_S: rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      ACC_HALF_U: rdata_ext = {16'b0, half_sel};
      ACC_HALF_S: rdata_ext = {{16{half_sel[15]}}, half_sel};
      default:    ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: turns M-stage load/store requests into a single
// valid/ready bus transaction, stalling the pipeline until it completes.
import mem_stage_lsu_pkg::*;

module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [2:0]  AccTypeM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        AlignFault,
  output logic        BusFault,
  output logic        BusValid,
  output logic        BusWrite,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusWStrb,
  input  logic        BusReady,
  input  logic [31:0] BusRData
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  acc_t        acc_q, acc_d;
  logic        store_q, store_d, bfault_q, bfault_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_strb;
  acc_t        acc_in;
  logic        access, in_req;

  lsu_lane u_lane (
    .acc       (acc_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (BusRData),
    .wdata_rep (st_wdata),
    .wstrb     (st_strb),
    .rdata_ext (ld_data)
  );

  assign acc_in = norm_acc(AccTypeM);
  assign access = MemWriteM | MemtoRegM;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    acc_d      = acc_q;
    store_d    = store_q;
    rdata_d    = rdata_q;
    bfault_d   = bfault_q;
    cnt_d      = cnt_q;
    StallM     = 1'b0;
    AlignFault = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access && is_aligned(acc_in, ALUResultM[1:0])) begin
          StallM   = 1'b1;
          addr_d   = ALUResultM;
          wdata_d  = WriteDataM;
          acc_d    = acc_in;
          store_d  = MemWriteM;
          rdata_d  = '0;
          bfault_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_REQ;
        end else if (access) begin
          AlignFault = 1'b1;
        end
      end
      ST_REQ: begin
        StallM = 1'b1;
        if (BusReady) begin
          rdata_d = store_q ? 32'd0 : ld_data;
          state_d = ST_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Abort: BusValid drops and the fault is reported in DONE.
          rdata_d  = '0;
          bfault_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      acc_q    <= ACC_WORD;
      store_q  <= 1'b0;
      rdata_q  <= '0;
      bfault_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      acc_q    <= acc_d;
      store_q  <= store_d;
      rdata_q  <= rdata_d;
      bfault_q <= bfault_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_req    = (state_q == ST_REQ);
  assign BusValid  = in_req;
  assign BusWrite  = in_req & store_q;
  assign BusAddr   = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign BusWData  = (in_req & store_q) ? st_wdata : 32'd0;
  assign BusWStrb  = (in_req & store_q) ? st_strb : 4'd0;
  assign ReadDataM = (state_q == ST_DONE) ? rdata_q : 32'd0;
  assign BusFault  = (state_q == ST_DONE) & bfault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, random
// accesses against a lane-arithmetic reference model, and reset corners.
module tb_mem_stage_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemtoRegM;
  logic [2:0]  AccTypeM;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, AlignFault, BusFault, BusValid, BusWrite, BusReady;
  logic [31:0] BusAddr, BusWData, BusRData;
  logic [3:0]  BusWStrb;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .AccTypeM(AccTypeM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM),
    .AlignFault(AlignFault), .BusFault(BusFault),
    .BusValid(BusValid), .BusWrite(BusWrite), .BusAddr(BusAddr),
    .BusWData(BusWData), .BusWStrb(BusWStrb),
    .BusReady(BusReady), .BusRData(BusRData)
  );

  typedef struct {
    bit        wr;
    bit        rd;
    bit [2:0]  acc;
    bit [31:0] addr;
    bit [31:0] wd;
    bit [31:0] brd;
    int        dly;
    bit        af;
    bit [3:0]  strb;
    bit [31:0] ewd;
    bit [31:0] erd;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  string cur_tag  = "";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%s]: got %h, expected %h", name, cur_tag, act, exp);
    end
  endtask

  // Reference model: access size in bytes, arithmetic lane placement.
  function automatic int acc_size(input bit [2:0] a);
    if (a == 3'd1 || a == 3'd2) return 1;
    if (a == 3'd3 || a == 3'd4) return 2;
    return 4;
  endfunction

  function automatic bit m_aligned(input bit [2:0] a, input bit [31:0] addr);
    return (addr % acc_size(a)) == 0;
  endfunction

  function automatic bit [3:0] m_strb(input bit [2:0] a, input bit [31:0] addr);
    int m;
    m = ((1 << acc_size(a)) - 1) << (addr % 4);
    return 4'(m);
  endfunction

  function automatic bit [31:0] m_wdata(input bit [2:0] a, input bit [31:0] wd);
    case (acc_size(a))
      1:       return (wd & 32'hFF) * 32'h01010101;
      2:       return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] a, input bit [31:0] addr, input bit [31:0] brd);
    longint v, span;
    span = 64'd1 << (8 * acc_size(a));
    v = (longint'(brd) >> (8 * (addr % 4))) % span;
    if ((a == 3'd2 || a == 3'd4) && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  task automatic drive_idle();
    MemWriteM = 0; MemtoRegM = 0; AccTypeM = 0; ALUResultM = 0; WriteDataM = 0;
  endtask

  task automatic do_access(input vec_t v);
    bit done;
    int reqc;
    bit tmo;
    tmo = (v.dly >= TO);
    @(posedge clk); #1;
    MemWriteM = v.wr; MemtoRegM = v.rd; AccTypeM = v.acc;
    ALUResultM = v.addr; WriteDataM = v.wd; BusReady = 0;
    @(negedge clk);
    if (v.af) begin
      chk("align_fault", AlignFault, 1);
      chk("align_stall", StallM, 0);
      chk("align_busvalid", BusValid, 0);
      chk("align_rdata", ReadDataM, 0);
      @(posedge clk); #1; drive_idle();
      @(negedge clk);
      chk("align_pulse_end", AlignFault, 0);
      chk("align_no_req", BusValid, 0);
      return;
    end
    chk("issue_stall", StallM, 1);
    chk("issue_align", AlignFault, 0);
    chk("issue_busvalid", BusValid, 0);
    done = 0;
    reqc = 0;
    for (int n = 0; n < TO && !done; n++) begin
      @(posedge clk); #1;
      BusReady = (n == v.dly);
      BusRData = (n == v.dly) ? v.brd : $urandom;
      @(negedge clk);
      reqc++;
      chk("req_busvalid", BusValid, 1);
      chk("req_stall", StallM, 1);
      chk("req_addr", BusAddr, {v.addr[31:2], 2'b00});
      chk("req_write", BusWrite, v.wr);
      if (v.wr) begin
        chk("req_wstrb", BusWStrb, v.strb);
        chk("req_wdata", BusWData, v.ewd);
      end
      if (BusReady || n == TO - 1) done = 1;
    end
    chk("req_cycles", reqc, tmo ? TO : v.dly + 1);
    @(posedge clk); #1; BusReady = 0; BusRData = $urandom;
    @(negedge clk);
    chk("done_stall", StallM, 0);
    chk("done_busvalid", BusValid, 0);
    chk("done_rdata", ReadDataM, v.erd);
    chk("done_busfault", BusFault, tmo);
    @(posedge clk); #1; drive_idle();
    @(negedge clk);
    chk("after_stall", StallM, 0);
    chk("after_busfault", BusFault, 0);
    chk("after_rdata", ReadDataM, 0);
  endtask

  vec_t tbl[15];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    //            wr rd acc  addr          wd            brd           dly af strb     ewd           erd
    tbl[0]  = '{1, 0, 3'd0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 4'b1111, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{0, 1, 3'd2, 32'h203, 32'h0,        32'h80112233, 0, 0, 4'b0000, 32'h0,        32'hFFFFFF80};
    tbl[2]  = '{0, 1, 3'd1, 32'h203, 32'h0,        32'h80112233, 0, 0, 4'b0000, 32'h0,        32'h00000080};
    tbl[3]  = '{1, 0, 3'd3, 32'h102, 32'h0000ABCD, 32'h0,        0, 0, 4'b1100, 32'hABCDABCD, 32'h0};
    tbl[4]  = '{0, 1, 3'd0, 32'h101, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};
    tbl[5]  = '{0, 1, 3'd4, 32'h200, 32'h0,        32'h12348001, 1, 0, 4'b0000, 32'h0,        32'hFFFF8001};
    tbl[6]  = '{0, 1, 3'd3, 32'h202, 32'h0,        32'hFEDC0000, 2, 0, 4'b0000, 32'h0,        32'h0000FEDC};
    tbl[7]  = '{1, 0, 3'd1, 32'h301, 32'h000000A5, 32'h0,        0, 0, 4'b0010, 32'hA5A5A5A5, 32'h0};
    tbl[8]  = '{0, 1, 3'd0, 32'h400, 32'h0,        32'h13579BDF, 3, 0, 4'b0000, 32'h0,        32'h13579BDF};
    tbl[9]  = '{0, 1, 3'd4, 32'h101, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};
    tbl[10] = '{0, 1, 3'd7, 32'h500, 32'h0,        32'hCAFEF00D, 0, 0, 4'b0000, 32'h0,        32'hCAFEF00D};
    tbl[11] = '{0, 1, 3'd6, 32'h502, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};
    tbl[12] = '{1, 1, 3'd0, 32'h600, 32'h11223344, 32'h99999999, 0, 0, 4'b1111, 32'h11223344, 32'h0};
    tbl[13] = '{0, 1, 3'd2, 32'h701, 32'h0,        32'h00007F00, 0, 0, 4'b0000, 32'h0,        32'h0000007F};
    tbl[14] = '{0, 1, 3'd0, 32'h800, 32'h0,        32'h55555555, 99, 0, 4'b0000, 32'h0,       32'h0};

    reset = 1; BusReady = 0; BusRData = 0; drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cur_tag = "reset";
    chk("rst_busvalid", BusValid, 0);
    chk("rst_buswrite", BusWrite, 0);
    chk("rst_wstrb", BusWStrb, 0);
    chk("rst_addr", BusAddr, 0);
    chk("rst_wdata", BusWData, 0);
    chk("rst_rdata", ReadDataM, 0);
    chk("rst_faults", {AlignFault, BusFault}, 0);
    @(posedge clk); #1; reset = 0;

    cur_tag = "no_access";
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_stall", StallM, 0);
      chk("idle_busvalid", BusValid, 0);
      chk("idle_rdata", ReadDataM, 0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 15; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      do_access(tbl[i]);
    end

    for (int i = 0; i < 40; i++) begin
      rv.acc  = 3'($urandom_range(0, 7));
      rv.addr = $urandom;
      rv.wd   = $urandom;
      rv.brd  = $urandom;
      rv.wr   = 1'($urandom_range(0, 1));
      rv.rd   = rv.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.dly  = ($urandom_range(0, 9) == 0) ? TO + 3 : int'($urandom_range(0, 4));
      rv.af   = !m_aligned(rv.acc, rv.addr);
      rv.strb = m_strb(rv.acc, rv.addr);
      rv.ewd  = m_wdata(rv.acc, rv.wd);
      rv.erd  = (rv.wr || rv.dly >= TO) ? 32'h0 : m_load(rv.acc, rv.addr, rv.brd);
      cur_tag = $sformatf("rand%0d", i);
      do_access(rv);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset on the third REQ cycle, coinciding with BusReady.
    cur_tag = "reset_in_req";
    @(posedge clk); #1;
    MemtoRegM = 1; AccTypeM = 3'd0; ALUResultM = 32'h900; BusReady = 0;
    @(negedge clk);
    chk("rr_issue_stall", StallM, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        reset = 1; BusReady = 1; BusRData = 32'h12345678; drive_idle();
      end
      @(negedge clk);
      chk("rr_busvalid", BusValid, 1);
    end
    @(posedge clk); #1; reset = 0; BusReady = 0;
    @(negedge clk);
    chk("rr_busvalid_drop", BusValid, 0);
    chk("rr_busfault", BusFault, 0);
    chk("rr_rdata", ReadDataM, 0);
    chk("rr_stall", StallM, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_busfault2", BusFault, 0);
    chk("rr_rdata2", ReadDataM, 0);
    chk("rr_busvalid2", BusValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
